// File: rtl/wc_pkg.sv
// Shared definitions for the Winograd F(2,3) front end.
// Contents:
//   WC_W       - default sample width in bits (signed two's complement)
//   NIN, NOUT  - samples per input tile and results per output tile
//   WC_LAT_DEF - default core latency, counted from tile issue to valid Z
//   feeder_state_e - feeder FSM states
//   lane_lo()  - lowest bit index of lane i in a packed tile (lane 0 sits at the top)
package wc_pkg;

  localparam int WC_W       = 10;
  localparam int NIN        = 4;
  localparam int NOUT       = 2;
  localparam int WC_LAT_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } feeder_state_e;

  // Lane i occupies bits [(NIN-i)*w-1 : (NIN-1-i)*w].
  function automatic int lane_lo(input int lane, input int w);
    return (NIN - 1 - lane) * w;
  endfunction

endpackage

// File: rtl/wc_tile_window.sv
// Sliding 4-sample window for the tile feeder.
// It collects accepted samples into lanes 0..3 and reports when the
// window is complete. A window is complete when lane 3 is filled or the
// sample carries last. When the window completes it slides by two, so the
// old d2/d3 become d0/d1. After a last tile it clears for the next frame.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   accept       - a sample is accepted this cycle
//   sample, last - accepted sample and its end-of-frame flag
//   tile         - window merged with the current sample, zero-padded past it
//   complete     - the accept this cycle finishes a tile
module wc_tile_window
  import wc_pkg::*;
#(
  parameter int W = WC_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           accept,
  input  logic [W-1:0]   sample,
  input  logic           last,
  output logic [NIN*W-1:0] tile,
  output logic           complete
);

  logic [W-1:0] win  [NIN];
  logic [W-1:0] lane [NIN];
  logic [1:0]   slot;

  // Lanes before the load slot come from storage, the slot itself takes the
  // incoming sample, and everything after it is zero. The zero lanes are the
  // padding that a last sample needs.
  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      if (i < int'(slot)) begin
        lane[i] = win[i];
      end else if (i == int'(slot)) begin
        lane[i] = sample;
      end else begin
        lane[i] = '0;
      end
    end
  end

  always_comb begin
    tile = '0;
    for (int i = 0; i < NIN; i++) begin
      tile[lane_lo(i, W) +: W] = lane[i];
    end
  end

  assign complete = accept && ((slot == 2'd3) || last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NIN; i++) win[i] <= '0;
      slot <= 2'd0;
    end else if (accept) begin
      if (complete) begin
        if (last) begin
          for (int i = 0; i < NIN; i++) win[i] <= '0;
          slot <= 2'd0;
        end else begin
          // Stride 2: keep the newest two samples as the next tile's head.
          win[0] <= lane[2];
          win[1] <= lane[3];
          win[2] <= '0;
          win[3] <= '0;
          slot   <= 2'd2;
        end
      end else begin
        win[slot] <= sample;
        slot      <= slot + 2'd1;
      end
    end
  end

endmodule

// File: rtl/wc_tile_feeder.sv
// Front end for the Winograd F(2,3) core. It turns a framed valid/ready
// sample stream into overlapping stride-2 tiles on the packed D bus. It
// holds each tile stable while the core computes. When Z is valid, it
// strobes z_strobe, and z_last marks the final tile of the frame.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   in_data/in_valid/in_ready/in_last - sample stream (signed W bits)
//   D                   - tile to core, d0 in the top lane
//   d_valid             - one-cycle pulse when a new tile appears on D
//   z_strobe, z_last    - core Z valid for the latest tile / tile was last
//   busy                - a frame is in progress
//   tile_cnt            - tiles issued in the current frame, saturating
module wc_tile_feeder
  import wc_pkg::*;
#(
  parameter int W      = WC_W,
  parameter int WC_LAT = WC_LAT_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [NIN*W-1:0] D,
  output logic             d_valid,
  output logic             z_strobe,
  output logic             z_last,
  output logic             busy,
  output logic [CNT_W-1:0] tile_cnt
);

  localparam logic [3:0] LAT_END = 4'(WC_LAT);

  feeder_state_e     state, state_next;
  logic [3:0]        lat_cnt;
  logic              last_tile;
  logic              accept;
  logic              issue;
  logic [NIN*W-1:0]  tile;

  assign in_ready = (state != WAIT);
  assign accept   = in_valid && in_ready;

  wc_tile_window #(.W(W)) u_window (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .sample   (in_data),
    .last     (in_last),
    .tile     (tile),
    .complete (issue)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // The strobe cycle is also the last WAIT cycle. The stream is therefore
  // only re-opened on the following cycle.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    z_strobe   = 1'b0;
    z_last     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = issue ? WAIT : FILL;
      end
      FILL: begin
        if (issue) state_next = WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_END) begin
          z_strobe   = 1'b1;
          z_last     = last_tile;
          state_next = last_tile ? IDLE : FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // lat_cnt is 0 in the d_valid cycle. The strobe fires when it reaches
  // WC_LAT. tile_cnt restarts on the first accept of a new frame, so it
  // keeps the count of a finished frame while the block is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      D         <= '0;
      d_valid   <= 1'b0;
      lat_cnt   <= 4'd0;
      last_tile <= 1'b0;
      tile_cnt  <= '0;
    end else begin
      d_valid <= issue;
      if (issue) begin
        D         <= tile;
        lat_cnt   <= 4'd0;
        last_tile <= in_last;
      end else if (state == WAIT && !z_strobe) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (accept && state == IDLE) begin
        tile_cnt <= issue ? CNT_W'(1) : '0;
      end else if (issue && tile_cnt != '1) begin
        tile_cnt <= tile_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Self-checking bench for wc_tile_feeder.
// A queue-based model predicts every output on every cycle. Directed
// frames then pin specific tiles, timings and flags to literal values.
module tb_wc_tile_feeder;

  localparam int W   = 10;
  localparam int LAT = 6;
  localparam int CW  = 16;

  logic            clk;
  logic            rst;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [4*W-1:0]  D;
  logic            d_valid;
  logic            z_strobe;
  logic            z_last;
  logic            busy;
  logic [CW-1:0]   tile_cnt;

  wc_tile_feeder #(.W(W), .WC_LAT(LAT), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .D        (D),
    .d_valid  (d_valid),
    .z_strobe (z_strobe),
    .z_last   (z_last),
    .busy     (busy),
    .tile_cnt (tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model. A frame is a list of samples. Tiles are 4-sample
  // windows at stride 2, and the last tile is zero-padded. Each tile is
  // followed by LAT+1 cycles with the stream closed, and the last of those
  // cycles carries the strobe.
  logic [W-1:0]   m_win [$];
  logic [4*W-1:0] m_D;
  int             m_since;
  bit             m_last;
  bit             m_active;
  int             m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_win.delete();
      m_D      = '0;
      m_since  = -1;
      m_last   = 1'b0;
      m_active = 1'b0;
      m_cnt    = 0;
    end else if (m_since >= 0) begin
      if (m_since == LAT) begin
        m_since = -1;
        if (m_last) m_active = 1'b0;
      end else begin
        m_since++;
      end
    end else if (in_valid) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_win.delete();
      end
      m_win.push_back(in_data);
      if (in_last || m_win.size() == 4) begin
        while (m_win.size() < 4) m_win.push_back('0);
        m_D = {m_win[0], m_win[1], m_win[2], m_win[3]};
        if (m_cnt < 65535) m_cnt++;
        m_since = 0;
        m_last  = in_last;
        if (in_last) m_win.delete();
        else begin
          void'(m_win.pop_front());
          void'(m_win.pop_front());
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus capture of tiles and
  // strobe timing for the directed literal checks.
  logic [4*W-1:0] cap_D [$];
  int             dv_q  [$];
  int             zs_q  [$];
  bit             zl_q  [$];
  int             zs_cnt = 0;
  int             zl_cnt = 0;

  always @(negedge clk) begin
    checkOutput("in_ready", 64'(in_ready), 64'(m_since < 0));
    checkOutput("d_valid",  64'(d_valid),  64'(m_since == 0));
    checkOutput("z_strobe", 64'(z_strobe), 64'(m_since == LAT));
    checkOutput("z_last",   64'(z_last),   64'(m_since == LAT && m_last));
    checkOutput("busy",     64'(busy),     64'(m_active));
    checkOutput("tile_cnt", 64'(tile_cnt), 64'(m_cnt));
    checkOutput("D",        64'(D),        64'(m_D));
    if (d_valid) begin
      cap_D.push_back(D);
      dv_q.push_back(cyc);
    end
    if (z_strobe) begin
      zs_cnt++;
      zs_q.push_back(cyc);
      zl_q.push_back(z_last);
      if (z_last) zl_cnt++;
    end
  end

  // Direct correlation y[k] = sum d[k+j]*g[j], g = [4,1,13], truncated to W bits.
  function automatic logic [2*W-1:0] core_z(input logic [4*W-1:0] d);
    int d0, d1, d2, d3, y0, y1;
    d0 = int'($signed(d[39:30]));
    d1 = int'($signed(d[29:20]));
    d2 = int'($signed(d[19:10]));
    d3 = int'($signed(d[9:0]));
    y0 = 4 * d0 + d1 + 13 * d2;
    y1 = 4 * d1 + d2 + 13 * d3;
    return {y0[W-1:0], y1[W-1:0]};
  endfunction

  function automatic logic [4*W-1:0] capD(input int i);
    if (cap_D.size() > i) return cap_D[i];
    return 'x;
  endfunction

  int acc_q [$];

  task automatic applyStimulus(input int s, input bit last, output int acc_cyc);
    bit rdy;
    bit ok;
    ok       = 1'b0;
    acc_cyc  = -1;
    in_data  = s[W-1:0];
    in_last  = last;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy     = in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no accept required accept of %0d", s);
    end
  endtask

  task automatic runFrame(input int s[$]);
    int a;
    int zl0;
    bit done;
    acc_q.delete();
    cap_D.delete();
    dv_q.delete();
    zs_q.delete();
    zl_q.delete();
    zl0 = zl_cnt;
    for (int i = 0; i < s.size(); i++) begin
      applyStimulus(s[i], i == s.size() - 1, a);
      acc_q.push_back(a);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    done     = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (zl_cnt > zl0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL frame_timeout: got no z_last required z_last");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    int zs0;
    bit seen;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_D",        64'(D),        64'h0);
    checkOutput("reset_busy",     64'(busy),     64'h0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single tile
    runFrame('{2, -10, 3, 4});
    checkOutput("single_D",      64'(capD(0)),           64'h00BF600C04);
    checkOutput("single_strobes", 64'(zs_q.size()),      64'd1);
    checkOutput("single_latency", 64'(zs_q[0] - dv_q[0]), 64'(LAT));
    checkOutput("single_zlast",  64'(zl_q[0]),           64'd1);
    checkOutput("single_core_z", 64'(core_z(capD(0))),   64'(20'b0000100101_0000001111));
    checkOutput("single_cnt",    64'(tile_cnt),          64'd1);

    // Slide by two
    runFrame('{2, -10, 3, 4, -19, -6});
    checkOutput("slide_D0",     64'(capD(0)),       64'h00BF600C04);
    checkOutput("slide_D1",     64'(capD(1)),       64'h00C04FB7FA);
    checkOutput("slide_zlast0", 64'(zl_q[0]),       64'd0);
    checkOutput("slide_zlast1", 64'(zl_q[1]),       64'd1);
    checkOutput("slide_cnt",    64'(tile_cnt),      64'd2);

    // Padding
    runFrame('{2, -10, 3});
    checkOutput("pad_D",     64'(capD(0)), 64'h00BF600C00);
    checkOutput("pad_zlast", 64'(zl_q[0]), 64'd1);
    checkOutput("pad_idle",  64'(busy),    64'd0);
    runFrame('{5});
    checkOutput("one_D",   64'(capD(0)),  64'h0140000000);
    checkOutput("one_cnt", 64'(tile_cnt), 64'd1);

    // Backpressure: sample 7 is held during WAIT and must be accepted on the cycle after the strobe
    runFrame('{1, 2, 3, 4, 7, 8});
    checkOutput("bp_D1",     64'(capD(1)),             64'({10'd3, 10'd4, 10'd7, 10'd8}));
    checkOutput("bp_lane_d2", 64'(capD(1)[2*W-1:W]),   64'd7);
    checkOutput("bp_accept", 64'(acc_q[4]),            64'(zs_q[0] + 1));

    // Reset while waiting for the core
    cap_D.delete();
    dv_q.delete();
    for (int i = 0; i < 4; i++) applyStimulus(i + 1, 1'b0, a);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dv_q.size() > 0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
    end
    checkOutput("abort_dvalid_seen", 64'(seen), 64'd1);
    zs0 = zs_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    checkOutput("abort_D",    64'(D),    64'h0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_no_strobe", 64'(zs_cnt), 64'(zs0));
    runFrame('{2, -10, 3, 4});
    checkOutput("after_abort_D",   64'(capD(0)),  64'h00BF600C04);
    checkOutput("after_abort_cnt", 64'(tile_cnt), 64'd1);

    // Full-scale values pass bit-exact
    runFrame('{-512, 511, -1, 0});
    checkOutput("fullscale_D", 64'(capD(0)), 64'({10'h200, 10'h1FF, 10'h3FF, 10'h000}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
